// File: rtl/mc_fork_ctrl.sv
// Multicast fork controller. It holds one flit and its residual destination list,
// and emits one copy per granted output port, in carpool or strict mode.
module mc_fork_ctrl #(
  parameter int NUM_PORT       = 5,
  parameter int GRP_W          = 4,
  parameter int DST_LIST_WIDTH = NUM_PORT * GRP_W,
  parameter int DATA_W         = 32,
  parameter int MODE           = 0,
  parameter int MAX_WAIT       = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DST_LIST_WIDTH-1:0]          in_dst,
  input  logic [DATA_W-1:0]                  in_data,
  output logic [NUM_PORT-1:0]                req_pv,
  input  logic [NUM_PORT-1:0]                gnt,
  output logic [NUM_PORT-1:0]                out_valid,
  output logic [NUM_PORT*DST_LIST_WIDTH-1:0] out_dst,
  output logic [DATA_W-1:0]                  out_data,
  output logic                               busy
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, FORK} state_t;

  state_t                             state, state_nxt;
  logic [DST_LIST_WIDTH-1:0]          res, res_nxt, prim_dst;
  logic [DATA_W-1:0]                  data_q;
  logic [WCNT_W-1:0]                  wcnt, wcnt_nxt;
  logic                               esc, esc_nxt;
  logic [NUM_PORT-1:0]                h, prim_oh, valid_nxt;
  logic [NUM_PORT*DST_LIST_WIDTH-1:0] dst_nxt;
  logic                               carpool, load;

  function automatic logic [DST_LIST_WIDTH-1:0] grp_mask(input int p);
    grp_mask = '0;
    grp_mask[p*GRP_W +: GRP_W] = '1;
  endfunction

  assign busy     = (state == FORK);
  assign in_ready = (state == IDLE);
  assign load     = in_valid && in_ready && (in_dst != '0);
  assign carpool  = (MODE == 0) || esc;

  always_comb begin
    for (int p = 0; p < NUM_PORT; p++)
      req_pv[p] = busy && (|res[p*GRP_W +: GRP_W]);
  end

  // Grants are meaningless outside FORK; strict mode honours only productive ports.
  assign h       = !busy ? '0 : (carpool ? gnt : (gnt & req_pv));
  assign prim_oh = h & (~h + NUM_PORT'(1));

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    wcnt_nxt  = wcnt;
    esc_nxt   = esc;
    valid_nxt = '0;
    dst_nxt   = '0;
    prim_dst  = res;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = FORK;
          res_nxt   = in_dst;
          wcnt_nxt  = '0;
          esc_nxt   = 1'b0;
        end
      end
      FORK: begin
        if (h == '0) begin
          if (wcnt != WCNT_W'(MAX_WAIT)) wcnt_nxt = wcnt + WCNT_W'(1);
          if (wcnt_nxt == WCNT_W'(MAX_WAIT)) esc_nxt = 1'b1;
        end else if (carpool) begin
          // Replicas take their own group; the primary carries everything else.
          for (int p = 0; p < NUM_PORT; p++) begin
            if (h[p] && !prim_oh[p] && ((res & grp_mask(p)) != '0)) begin
              valid_nxt[p] = 1'b1;
              dst_nxt[p*DST_LIST_WIDTH +: DST_LIST_WIDTH] = res & grp_mask(p);
              prim_dst = prim_dst & ~grp_mask(p);
            end
          end
          for (int p = 0; p < NUM_PORT; p++) begin
            if (prim_oh[p]) begin
              valid_nxt[p] = 1'b1;
              dst_nxt[p*DST_LIST_WIDTH +: DST_LIST_WIDTH] = prim_dst;
            end
          end
          res_nxt   = '0;
          wcnt_nxt  = '0;
          esc_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          for (int p = 0; p < NUM_PORT; p++) begin
            if (h[p]) begin
              valid_nxt[p] = 1'b1;
              dst_nxt[p*DST_LIST_WIDTH +: DST_LIST_WIDTH] = res & grp_mask(p);
              res_nxt = res_nxt & ~grp_mask(p);
            end
          end
          wcnt_nxt = '0;
          if (res_nxt == '0) begin
            state_nxt = IDLE;
            esc_nxt   = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      res       <= '0;
      data_q    <= '0;
      wcnt      <= '0;
      esc       <= 1'b0;
      out_valid <= '0;
      out_dst   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      res       <= res_nxt;
      wcnt      <= wcnt_nxt;
      esc       <= esc_nxt;
      out_valid <= valid_nxt;
      out_dst   <= dst_nxt;
      out_data  <= (valid_nxt != '0) ? data_q : '0;
      if (load) data_q <= in_data;
    end
  end

endmodule
